// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan path: segment table, idle
// drive levels, digit count and the per-slot phase type.
package seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low idle levels: every segment off, no digit selected.
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] SEL_OFF = 4'hF;

    // Active-high gfedcba patterns for hex digits 0..F.
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Phase within one digit slot: dark guard interval, then the digit.
    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

endpackage

// File: rtl/seg_scan_ctrl_hex7_decode.sv
// Combinational hex nibble plus decimal point to active-low segment drive.
// Bit order of seg: [6:0] = g..a, [7] = dp.
module seg_hex7_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    // Table lookup, then invert everything for the common-anode shield.
    always_comb begin
        seg = ~{dp, HEX7_TABLE[nibble]};
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scan controller.
// A slot timer walks the digits; each slot opens with a dark guard interval
// against ghosting. New contents arrive through a load/ready handshake into a
// shadow register and are only copied to the displayed (active) set at a frame
// boundary, so a frame never shows a mix of old and new digits.
//
// Handshake: a transfer happens on a rising clk edge where load && load_ready.
// load_ready stays low from that transfer until the frame boundary that commits
// the shadow; load while load_ready is low is simply dropped, nothing queues.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGIT_CYCLES = 25000,
    parameter int BLANK_CYCLES = 100
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    output logic        load_ready,
    input  logic [15:0] load_value,
    input  logic [3:0]  load_en,
    input  logic [3:0]  load_dp,
    output logic [3:0]  io_sel,
    output logic [7:0]  io_seg,
    output logic [1:0]  cur_digit,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // A slot must have at least one dark cycle and at least one lit cycle.
    if (BLANK_CYCLES >= DIGIT_CYCLES || BLANK_CYCLES == 0) begin : g_bad_params
        $fatal(1, "seg_scan_ctrl: need 0 < BLANK_CYCLES < DIGIT_CYCLES");
    end

    logic [CNT_W-1:0] cnt;
    phase_t           phase;
    logic             slot_end;
    logic             frame_evt;

    logic [15:0] active_value;
    logic [3:0]  active_en;
    logic [3:0]  active_dp;
    logic [15:0] shadow_value;
    logic [3:0]  shadow_en;
    logic [3:0]  shadow_dp;
    logic        pending;

    logic [3:0]  cur_nibble;
    logic        cur_dp;
    logic        cur_en;
    logic [7:0]  dec_seg;
    logic [3:0]  sel_d;
    logic [7:0]  seg_d;

    // Slot timer: cnt runs through one slot, cur_digit advances at its end.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cur_digit <= 2'd0;
        end else if (slot_end) begin
            cnt       <= '0;
            cur_digit <= cur_digit + 2'd1;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Phase and boundary decode from the timer state.
    always_comb begin
        phase     = (cnt < CNT_BLANK) ? PH_BLANK : PH_SHOW;
        slot_end  = (cnt == CNT_LAST);
        frame_evt = slot_end && (cur_digit == 2'(NUM_DIGITS - 1));
    end

    // Pick the active digit's nibble, dp and enable for the current slot.
    always_comb begin
        cur_nibble = active_value[{cur_digit, 2'b00} +: 4];
        cur_dp     = active_dp[cur_digit];
        cur_en     = active_en[cur_digit];
    end

    seg_hex7_decode u_decode (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .seg    (dec_seg)
    );

    // Next drive levels: dark during BLANK or for a disabled digit.
    always_comb begin
        sel_d = SEL_OFF;
        seg_d = SEG_OFF;
        if (phase == PH_SHOW && cur_en) begin
            sel_d = ~(4'b0001 << cur_digit);
            seg_d = dec_seg;
        end
    end

    // Registered pin drive and frame pulse, one clk behind the timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_sel     <= SEL_OFF;
            io_seg     <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            io_sel     <= sel_d;
            io_seg     <= seg_d;
            frame_tick <= frame_evt;
        end
    end

    // Shadow capture and frame-boundary commit. A commit and a capture never
    // coincide: while pending is set load_ready is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_value <= '0;
            active_en    <= '0;
            active_dp    <= '0;
            shadow_value <= '0;
            shadow_en    <= '0;
            shadow_dp    <= '0;
            pending      <= 1'b0;
            load_ready   <= 1'b1;
        end else if (frame_evt && pending) begin
            active_value <= shadow_value;
            active_en    <= shadow_en;
            active_dp    <= shadow_dp;
            pending      <= 1'b0;
            load_ready   <= 1'b1;
        end else if (load && load_ready) begin
            shadow_value <= load_value;
            shadow_en    <= load_en;
            shadow_dp    <= load_dp;
            pending      <= 1'b1;
            load_ready   <= 1'b0;
        end
    end

endmodule
